// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive-side frame deserializer.
//   rxState_e       : receiver FSM states (IDLE, DATA, PARITY, STOP)
//   PAR_EVEN/ODD    : encoding of the PAR_TYP configuration bit
//   DEF_DATA_WIDTH  : default number of data bits per frame
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam int   DEF_DATA_WIDTH = 8;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rxState_e;

endpackage

// File: rtl/uart_rx_frame_deser_if.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_deser_if
// Bundles the receive deserializer's bit stream input, frame configuration
// and result outputs.
//   sampled_bit / bit_valid : one voted line bit per bit period, with strobe
//   PAR_EN / PAR_TYP        : parity present / odd parity select
//   P_DATA / Data_Valid     : received byte and its one-cycle delivery pulse
//   par_err / stp_err       : error flags of the last frame
//   busy                    : a frame is in progress
// master modport: the upstream sampler / configuration side.
// slave modport : the deserializer itself.
// ---------------------------------------------------------------------------
interface uart_rx_frame_deser_if
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

    logic                  sampled_bit;
    logic                  bit_valid;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  busy;

    modport master (
        output sampled_bit, bit_valid, PAR_EN, PAR_TYP,
        input  P_DATA, Data_Valid, par_err, stp_err, busy
    );

    modport slave (
        input  sampled_bit, bit_valid, PAR_EN, PAR_TYP,
        output P_DATA, Data_Valid, par_err, stp_err, busy
    );

endinterface

// File: rtl/uart_rx_parity_check.sv
// ---------------------------------------------------------------------------
// uart_rx_parity_check
// Combinational parity judge for one received data word.
//   data_i     : the deserialized data bits
//   par_typ_i  : parity type latched for this frame (PAR_EVEN / PAR_ODD)
//   par_bit_i  : parity bit received from the line
//   mismatch_o : 1 when the received parity bit disagrees with the data
// ---------------------------------------------------------------------------
module uart_rx_parity_check
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  par_typ_i,
    input  logic                  par_bit_i,
    output logic                  mismatch_o
);

    logic expectedBit;

    // Even parity makes the total count of ones even; odd parity inverts it.
    assign expectedBit = (^data_i) ^ (par_typ_i == PAR_ODD);
    assign mismatch_o  = (par_bit_i != expectedBit);

endmodule

// File: rtl/uart_rx_frame_deser.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_deser
// UART receive frame deserializer: detects the start bit, shifts data in
// LSB-first, checks the optional parity bit and the stop bit, and delivers
// good bytes with a one-cycle Data_Valid pulse.
//   CLK : system clock
//   RST : synchronous active-high reset
//   bus : uart_rx_frame_deser_if.slave (bit stream in, config, results out)
// All state and output updates happen on bit_valid cycles, except the
// automatic clear of the Data_Valid pulse.
// ---------------------------------------------------------------------------
module uart_rx_frame_deser
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    CLK,
    input  logic                    RST,
    uart_rx_frame_deser_if.slave    bus
);

    localparam int              CNT_W    = $clog2(DATA_WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    rxState_e              state_q,     state_d;
    logic [DATA_WIDTH-1:0] shift_q,     shift_d;
    logic [CNT_W-1:0]      cnt_q,       cnt_d;
    logic                  parEn_q,     parEn_d;
    logic                  parTyp_q,    parTyp_d;
    logic [DATA_WIDTH-1:0] pData_q,     pData_d;
    logic                  dataValid_q, dataValid_d;
    logic                  parErr_q,    parErr_d;
    logic                  stpErr_q,    stpErr_d;
    logic                  parMismatch;

    // In PARITY the shift register already holds the complete data word,
    // and the line bit being sampled is the parity bit.
    uart_rx_parity_check #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .data_i     (shift_q),
        .par_typ_i  (parTyp_q),
        .par_bit_i  (bus.sampled_bit),
        .mismatch_o (parMismatch)
    );

    // State and datapath registers; reset overrides any frame in progress.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            cnt_q       <= '0;
            parEn_q     <= 1'b0;
            parTyp_q    <= 1'b0;
            pData_q     <= '0;
            dataValid_q <= 1'b0;
            parErr_q    <= 1'b0;
            stpErr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            parEn_q     <= parEn_d;
            parTyp_q    <= parTyp_d;
            pData_q     <= pData_d;
            dataValid_q <= dataValid_d;
            parErr_q    <= parErr_d;
            stpErr_q    <= stpErr_d;
        end
    end

    // Next-state logic. The parity state is skipped when the frame was
    // started without parity; STOP returns to IDLE so a start bit on the
    // very next bit_valid is accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.bit_valid && !bus.sampled_bit) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bus.bit_valid && (cnt_q == LAST_BIT)) begin
                    state_d = parEn_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bus.bit_valid) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (bus.bit_valid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output updates. Configuration is captured at the start
    // bit so mid-frame changes on PAR_EN/PAR_TYP cannot corrupt the frame.
    // Errored frames leave P_DATA untouched and keep their flag raised
    // until the next start bit.
    always_comb begin
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        parEn_d     = parEn_q;
        parTyp_d    = parTyp_q;
        pData_d     = pData_q;
        dataValid_d = 1'b0;
        parErr_d    = parErr_q;
        stpErr_d    = stpErr_q;
        case (state_q)
            IDLE: begin
                if (bus.bit_valid && !bus.sampled_bit) begin
                    cnt_d    = '0;
                    parErr_d = 1'b0;
                    stpErr_d = 1'b0;
                    parEn_d  = bus.PAR_EN;
                    parTyp_d = bus.PAR_TYP;
                end
            end
            DATA: begin
                if (bus.bit_valid) begin
                    shift_d = {bus.sampled_bit, shift_q[DATA_WIDTH-1:1]};
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            PARITY: begin
                if (bus.bit_valid) begin
                    parErr_d = parMismatch;
                end
            end
            STOP: begin
                if (bus.bit_valid) begin
                    stpErr_d = ~bus.sampled_bit;
                    if (!parErr_q && bus.sampled_bit) begin
                        pData_d     = shift_q;
                        dataValid_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign bus.P_DATA     = pData_q;
    assign bus.Data_Valid = dataValid_q;
    assign bus.par_err    = parErr_q;
    assign bus.stp_err    = stpErr_q;
    assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_deser.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame_deser
// Self-checking bench for uart_rx_frame_deser. Frames are described at the
// byte level (data, parity config, parity bit, stop bit) and the expected
// outcome is derived from a bit-counting parity model. A monitor records
// every Data_Valid pulse with its cycle number and byte.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame_deser;
    import uart_pkg::*;

    localparam int DW = 8;

    logic CLK = 1'b0;
    logic RST;

    int nTests = 0;
    int nFail  = 0;
    int cycle  = 0;

    int            dvCycle[$];
    logic [DW-1:0] dvData[$];
    logic [DW-1:0] lastGood;

    uart_rx_frame_deser_if #(.DATA_WIDTH(DW)) bus ();

    uart_rx_frame_deser #(.DATA_WIDTH(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Record every delivered byte together with the cycle it appeared on.
    always @(negedge CLK) begin
        cycle <= cycle + 1;
        if (bus.Data_Valid === 1'b1) begin
            dvCycle.push_back(cycle);
            dvData.push_back(bus.P_DATA);
        end
    end

    // Guard against a hung run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // Correct parity bit: count the ones; even parity makes the total even.
    function automatic logic modelParity(input logic [DW-1:0] d, input logic typ);
        int ones = 0;
        for (int i = 0; i < DW; i++) begin
            if (d[i]) ones++;
        end
        return ((ones % 2) == 1) ^ (typ == PAR_ODD);
    endfunction

    // One line bit, then an optional run of cycles without bit_valid.
    task automatic driveBit(input logic b, input int gap);
        @(negedge CLK);
        bus.sampled_bit = b;
        bus.bit_valid   = 1'b1;
        for (int g = 0; g < gap; g++) begin
            @(negedge CLK);
            bus.bit_valid   = 1'b0;
            bus.sampled_bit = 1'($urandom_range(0, 1));
        end
    endtask

    // Whole frame: start, data LSB first, optional parity, stop.
    task automatic sendFrame(input logic [DW-1:0] data, input logic parEn,
                             input logic parTyp, input logic parBit,
                             input logic stopBit, input int maxGap,
                             input logic toggleCfg);
        bus.PAR_EN  = parEn;
        bus.PAR_TYP = parTyp;
        driveBit(1'b0, $urandom_range(0, maxGap));
        for (int i = 0; i < DW; i++) begin
            driveBit(data[i], $urandom_range(0, maxGap));
            if (toggleCfg && i == 3) begin
                bus.PAR_TYP = ~bus.PAR_TYP;
                bus.PAR_EN  = ~bus.PAR_EN;
            end
        end
        if (parEn) driveBit(parBit, $urandom_range(0, maxGap));
        driveBit(stopBit, $urandom_range(0, maxGap));
    endtask

    // Drop bit_valid and let any Data_Valid pulse be recorded.
    task automatic settle();
        @(negedge CLK);
        bus.bit_valid = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
    endtask

    task automatic test_reset();
        RST             = 1'b1;
        bus.bit_valid   = 1'b0;
        bus.sampled_bit = 1'b1;
        bus.PAR_EN      = 1'b0;
        bus.PAR_TYP     = 1'b0;
        repeat (3) @(negedge CLK);
        nTests++;
        if (bus.busy !== 1'b0) begin
            nFail++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy);
        end
        nTests++;
        if (bus.P_DATA !== 8'h00) begin
            nFail++; $display("[TB] FAIL reset_pdata got %h want 00", bus.P_DATA);
        end
        nTests++;
        if ({bus.Data_Valid, bus.par_err, bus.stp_err} !== 3'b000) begin
            nFail++;
            $display("[TB] FAIL reset_flags got dv/pe/se=%b%b%b want 000",
                     bus.Data_Valid, bus.par_err, bus.stp_err);
        end
        RST      = 1'b0;
        lastGood = '0;
    endtask

    task automatic test_good_frame();
        logic pb;
        pb = modelParity(8'hA5, PAR_EVEN);
        dvData.delete(); dvCycle.delete();
        bus.PAR_EN  = 1'b1;
        bus.PAR_TYP = PAR_EVEN;
        driveBit(1'b0, 0);
        driveBit(1'b1, 0); driveBit(1'b0, 0); driveBit(1'b1, 0); driveBit(1'b0, 0);
        driveBit(1'b0, 0); driveBit(1'b1, 0); driveBit(1'b0, 0); driveBit(1'b1, 0);
        driveBit(pb, 0);
        driveBit(1'b1, 0);
        @(negedge CLK);
        bus.bit_valid = 1'b0;
        nTests++;
        if (bus.Data_Valid !== 1'b1 || bus.P_DATA !== 8'hA5) begin
            nFail++;
            $display("[TB] FAIL good_a5_deliver got dv=%b data=%h want dv=1 data=a5",
                     bus.Data_Valid, bus.P_DATA);
        end
        nTests++;
        if (bus.par_err !== 1'b0 || bus.stp_err !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL good_a5_flags got pe=%b se=%b want 0 0",
                     bus.par_err, bus.stp_err);
        end
        @(negedge CLK);
        nTests++;
        if (bus.Data_Valid !== 1'b0) begin
            nFail++; $display("[TB] FAIL good_a5_pulse_width got dv=%b want 0", bus.Data_Valid);
        end
        lastGood = 8'hA5;
    endtask

    task automatic test_parity_error();
        logic pb;
        pb = ~modelParity(8'h07, PAR_ODD);
        dvData.delete(); dvCycle.delete();
        sendFrame(8'h07, 1'b1, PAR_ODD, pb, 1'b1, 1, 1'b0);
        settle();
        nTests++;
        if (bus.par_err !== 1'b1) begin
            nFail++; $display("[TB] FAIL parity_err_flag got %b want 1", bus.par_err);
        end
        nTests++;
        if (dvData.size() != 0 || bus.P_DATA !== lastGood) begin
            nFail++;
            $display("[TB] FAIL parity_err_no_deliver got pulses=%0d data=%h want 0 %h",
                     dvData.size(), bus.P_DATA, lastGood);
        end
    endtask

    task automatic test_stop_error();
        dvData.delete(); dvCycle.delete();
        sendFrame(8'h3C, 1'b0, PAR_EVEN, 1'b0, 1'b0, 1, 1'b0);
        settle();
        nTests++;
        if (bus.stp_err !== 1'b1 || dvData.size() != 0 || bus.P_DATA !== lastGood) begin
            nFail++;
            $display("[TB] FAIL stop_err got se=%b pulses=%0d data=%h want 1 0 %h",
                     bus.stp_err, dvData.size(), bus.P_DATA, lastGood);
        end
        bus.PAR_EN = 1'b0;
        driveBit(1'b0, 0);
        @(negedge CLK);
        bus.bit_valid = 1'b0;
        nTests++;
        if (bus.stp_err !== 1'b0 || bus.busy !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL stop_err_clear_at_start got se=%b busy=%b want 0 1",
                     bus.stp_err, bus.busy);
        end
        for (int i = 0; i < DW; i++) driveBit(((8'h3C >> i) & 8'h01) != 0, 0);
        driveBit(1'b1, 0);
        settle();
        nTests++;
        if (dvData.size() != 1 || bus.P_DATA !== 8'h3C || bus.stp_err !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL stop_err_recover got pulses=%0d data=%h se=%b want 1 3c 0",
                     dvData.size(), bus.P_DATA, bus.stp_err);
        end
        lastGood = 8'h3C;
    endtask

    task automatic test_reset_mid_frame();
        dvData.delete(); dvCycle.delete();
        bus.PAR_EN  = 1'b1;
        bus.PAR_TYP = PAR_EVEN;
        driveBit(1'b0, 0);
        repeat (4) driveBit(1'b1, 0);
        @(negedge CLK);
        RST             = 1'b1;
        bus.bit_valid   = 1'b1;
        bus.sampled_bit = 1'b0;
        @(negedge CLK);
        nTests++;
        if (bus.busy !== 1'b0 || bus.P_DATA !== 8'h00 ||
            {bus.Data_Valid, bus.par_err, bus.stp_err} !== 3'b000) begin
            nFail++;
            $display("[TB] FAIL reset_mid_frame got busy=%b data=%h dv/pe/se=%b%b%b want 0 00 000",
                     bus.busy, bus.P_DATA, bus.Data_Valid, bus.par_err, bus.stp_err);
        end
        RST           = 1'b0;
        bus.bit_valid = 1'b0;
        lastGood      = '0;
        sendFrame(8'h81, 1'b1, PAR_EVEN, modelParity(8'h81, PAR_EVEN), 1'b1, 0, 1'b0);
        settle();
        nTests++;
        if (dvData.size() != 1 || bus.P_DATA !== 8'h81) begin
            nFail++;
            $display("[TB] FAIL reset_recover got pulses=%0d data=%h want 1 81",
                     dvData.size(), bus.P_DATA);
        end
        lastGood = 8'h81;
    endtask

    task automatic test_back_to_back();
        dvData.delete(); dvCycle.delete();
        repeat (3) driveBit(1'b1, 0);
        sendFrame(8'h55, 1'b1, PAR_EVEN, modelParity(8'h55, PAR_EVEN), 1'b1, 0, 1'b0);
        sendFrame(8'hAA, 1'b1, PAR_EVEN, modelParity(8'hAA, PAR_EVEN), 1'b1, 0, 1'b0);
        settle();
        nTests++;
        if (dvData.size() != 2) begin
            nFail++; $display("[TB] FAIL b2b_count got %0d want 2", dvData.size());
        end else begin
            nTests++;
            if (dvData[0] !== 8'h55 || dvData[1] !== 8'hAA) begin
                nFail++;
                $display("[TB] FAIL b2b_data got %h %h want 55 aa", dvData[0], dvData[1]);
            end
            nTests++;
            if (dvCycle[1] - dvCycle[0] != 3 + DW) begin
                nFail++;
                $display("[TB] FAIL b2b_spacing got %0d want %0d",
                         dvCycle[1] - dvCycle[0], 3 + DW);
            end
        end
        lastGood = 8'hAA;
    endtask

    task automatic test_cfg_latch();
        dvData.delete(); dvCycle.delete();
        sendFrame(8'hF0, 1'b1, PAR_EVEN, 1'b0, 1'b1, 1, 1'b1);
        settle();
        nTests++;
        if (bus.par_err !== 1'b0 || dvData.size() != 1 || bus.P_DATA !== 8'hF0) begin
            nFail++;
            $display("[TB] FAIL cfg_latch got pe=%b pulses=%0d data=%h want 0 1 f0",
                     bus.par_err, dvData.size(), bus.P_DATA);
        end
        lastGood = 8'hF0;
    endtask

    task automatic test_random_frames();
        logic [DW-1:0] data;
        logic parEn, parTyp, parBit, stopBit, good, expPe;
        for (int n = 0; n < 40; n++) begin
            data    = DW'($urandom);
            parEn   = 1'($urandom_range(0, 1));
            parTyp  = 1'($urandom_range(0, 1));
            parBit  = modelParity(data, parTyp) ^ ($urandom_range(0, 3) == 0);
            stopBit = ($urandom_range(0, 4) != 0);
            expPe   = parEn && (parBit != modelParity(data, parTyp));
            good    = !expPe && stopBit;
            dvData.delete(); dvCycle.delete();
            repeat ($urandom_range(0, 2)) driveBit(1'b1, 0);
            sendFrame(data, parEn, parTyp, parBit, stopBit, 2, 1'($urandom_range(0, 1)));
            settle();
            if (good) lastGood = data;
            nTests++;
            if (dvData.size() != int'(good)) begin
                nFail++;
                $display("[TB] FAIL rand%0d_pulses got %0d want %0d", n, dvData.size(), int'(good));
            end else if (good) begin
                nTests++;
                if (dvData[0] !== data) begin
                    nFail++;
                    $display("[TB] FAIL rand%0d_dv_data got %h want %h", n, dvData[0], data);
                end
            end
            nTests++;
            if (bus.P_DATA !== lastGood || bus.par_err !== expPe ||
                bus.stp_err !== !stopBit || bus.busy !== 1'b0) begin
                nFail++;
                $display("[TB] FAIL rand%0d_state got data=%h pe=%b se=%b busy=%b want %h %b %b 0",
                         n, bus.P_DATA, bus.par_err, bus.stp_err, bus.busy,
                         lastGood, expPe, !stopBit);
            end
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_parity_error();
        test_stop_error();
        test_reset_mid_frame();
        test_back_to_back();
        test_cfg_latch();
        test_random_frames();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
